// File: rtl/mem_responder.sv
// Word-addressed RAM responder for the core memory port with programmable wait states.
// Latency: ready is high in the cycle after edge WAIT_STATES+1 (accept edge = edge 0).
// Backpressure: one request at a time; new requests are ignored until the FSM is back in IDLE.
module mem_responder #(
  parameter int ADDR_BITS   = 9,
  parameter int DEPTH       = 512,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Read,
  input  logic        write_mem,
  input  logic [31:0] MAR,
  input  logic [31:0] OUT_MDR,
  output logic [31:0] BusMuxIn_MDR,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_DONE,
    S_RELEASE
  } state_t;

  // Counter preload; only meaningful when there is at least one wait state.
  localparam logic [3:0] LP_CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam bit         LP_HAS_WAIT = (WAIT_STATES > 0);

  state_t                 r_state;
  state_t                 w_next;
  logic [3:0]             r_cnt;
  logic                   r_wr;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [31:0]            r_wdata;
  logic                   r_oor;
  logic                   r_ill_err;
  logic [31:0]            r_rdata;
  logic [31:0]            r_mem [DEPTH];

  logic w_accept;
  logic w_illegal;
  logic w_ready;

  assign w_accept  = (r_state == S_IDLE) && (Read ^ write_mem);
  assign w_illegal = (r_state == S_IDLE) && Read && write_mem;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and ready decode.
  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_illegal) begin
          w_next = S_RELEASE;
        end else if (w_accept) begin
          w_next = LP_HAS_WAIT ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_next = S_DONE;
      end
      S_DONE: begin
        w_ready = 1'b1;
        w_next  = (Read || write_mem) ? S_RELEASE : S_IDLE;
      end
      S_RELEASE: begin
        if (!Read && !write_mem) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Latch the request on accept so later input changes cannot disturb it; run the wait counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= 4'd0;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= 32'd0;
      r_oor     <= 1'b0;
      r_ill_err <= 1'b0;
    end else begin
      r_ill_err <= w_illegal;
      if (w_accept) begin
        r_cnt   <= LP_CNT_LOAD;
        r_wr    <= write_mem;
        r_addr  <= MAR[ADDR_BITS-1:0];
        r_wdata <= OUT_MDR;
        r_oor   <= |MAR[31:ADDR_BITS];
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Read data register: only a completed read updates it, out-of-range reads return zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata <= 32'd0;
    end else if (r_state == S_ACCESS && !r_wr) begin
      r_rdata <= r_oor ? 32'd0 : r_mem[r_addr];
    end
  end

  // RAM write port; contents survive reset, out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (r_state == S_ACCESS && r_wr && !r_oor) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  assign BusMuxIn_MDR = r_rdata;
  assign ready        = w_ready;
  assign busy         = (r_state != S_IDLE);
  assign err          = ((r_state == S_ACCESS) && r_oor) || r_ill_err;

endmodule
